// File: rtl/regfile_wb_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler_pkg
//   Shared constants, the write-request record and small helpers used by the
//   regfile write-port scheduler and its result FIFO.
//
//   Contents:
//     ADDR_W / DATA_W   default GPR address / data widths
//     NUM_GPR           number of architectural GPRs (busy scoreboard width)
//     ZERO_REG          hard-wired zero register index
//     wb_req_t          {valid, addr, data} write request record
//     gpr_onehot()      address -> scoreboard bit vector, zero register masked
// ---------------------------------------------------------------------------
package regfile_wb_scheduler_pkg;

    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int NUM_GPR = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

    // One candidate for the regfile write port.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Decode a GPR address into a scoreboard vector. The zero register bit is
    // always cleared so that no set/clear can ever touch busy[0].
    function automatic logic [NUM_GPR-1:0] gpr_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_GPR-1:0] vec;
        vec           = '0;
        vec[addr]     = 1'b1;
        vec[ZERO_REG] = 1'b0;
        return vec;
    endfunction

endpackage : regfile_wb_scheduler_pkg

// File: rtl/regfile_wb_scheduler_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
//   Synchronous FIFO holding long-latency results ({addr, data}) until the
//   regfile write port is free. Push uses a valid/ready handshake; the head is
//   always visible and is removed by asserting pop.
//
//   Ports:
//     clk, rst     clock, synchronous active-high reset (empties the FIFO)
//     push_valid   offer an entry; accepted when push_valid && push_ready
//     push_ready   FIFO not full (a same-cycle pop is not taken into account)
//     push_addr    entry destination GPR
//     push_data    entry data
//     pop          remove the head at the edge (ignored when empty)
//     pop_valid    FIFO not empty, head_* are meaningful
//     head_addr    head entry destination GPR
//     head_data    head entry data
// ---------------------------------------------------------------------------
module wb_result_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              pop_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);
    import regfile_wb_scheduler_pkg::*;

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_d;
    logic [PTR_W:0]     wr_ptr_q;
    logic [PTR_W:0]     rd_ptr_d;
    logic [PTR_W:0]     rd_ptr_q;

    logic               full_s;
    logic               empty_s;
    logic               do_push_s;
    logic               do_pop_s;
    logic [PTR_W-1:0]   wr_idx_s;
    logic [PTR_W-1:0]   rd_idx_s;

    // Pointers carry one extra wrap bit: equal -> empty, only wrap bit differs -> full.
    always_comb begin
        wr_idx_s  = wr_ptr_q[PTR_W-1:0];
        rd_idx_s  = rd_ptr_q[PTR_W-1:0];
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx_s == rd_idx_s);
        do_push_s = push_valid && !full_s;
        do_pop_s  = pop && !empty_s;
    end

    // Next-state for storage and pointers.
    always_comb begin
        mem_d = mem_q;
        if (do_push_s) begin
            mem_d[wr_idx_s] = {push_addr, push_data};
        end else begin
            mem_d = mem_q;
        end

        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Head is read straight from storage; it is only consumed when pop_valid.
    always_comb begin
        push_ready = !full_s;
        pop_valid  = !empty_s;
        {head_addr, head_data} = mem_q[rd_idx_s];
    end

endmodule : wb_result_fifo

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//   Shares the single register-file write port between the pipeline WB stage
//   and a long-latency (MUL/DIV) unit. A 32-entry busy scoreboard tracks GPRs
//   waiting for long-latency results and stalls ID on RAW/WAW hazards. Results
//   that cannot be written immediately wait in wb_result_fifo.
//
//   Write-port priority: WB (non-zero destination) > FIFO head > (bypass).
//
//   Optional feature, macro LU_WB_BYPASS_EN:
//     defined   - with no WB request and an empty FIFO, an lu_done handshake
//                 writes the regfile in the same cycle and skips the FIFO.
//     undefined - every result goes through the FIFO (>= 1 cycle latency).
//
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     wb_valid/addr/data              pipeline WB write request
//     lu_issue_valid/addr             long-latency op issued, marks dest busy
//     lu_done_valid/addr/data/ready   long-latency result handshake
//     id_rs/rt_addr, id_rs/rt_ena     ID source operands
//     id_rd_addr, id_rd_wena          ID destination
//     issue_stall                     hold ID stage (RAW/WAW on busy GPR)
//     rf_wena/waddr/wdata             register-file write port
//     busy_mask                       scoreboard state (registered)
//     proto_err                       sticky protocol-error flag
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
    parameter int ADDR_W      = regfile_wb_scheduler_pkg::ADDR_W,
    parameter int DATA_W      = regfile_wb_scheduler_pkg::DATA_W,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lu_issue_valid,
    input  logic [ADDR_W-1:0] lu_issue_addr,
    input  logic              lu_done_valid,
    input  logic [ADDR_W-1:0] lu_done_addr,
    input  logic [DATA_W-1:0] lu_done_data,
    output logic              lu_done_ready,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic              id_rs_ena,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rt_ena,
    input  logic [ADDR_W-1:0] id_rd_addr,
    input  logic              id_rd_wena,
    output logic              issue_stall,
    output logic              rf_wena,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [regfile_wb_scheduler_pkg::NUM_GPR-1:0] busy_mask,
    output logic              proto_err
);
    import regfile_wb_scheduler_pkg::*;

    logic [NUM_GPR-1:0] busy_d;
    logic [NUM_GPR-1:0] busy_q;
    logic               proto_err_d;
    logic               proto_err_q;

    wb_req_t            wb_req_s;
    logic               lu_done_ready_s;
    logic               lu_accept_s;
    logic               lu_nonzero_s;
    logic               fifo_push_s;
    logic               fifo_push_ready_s;
    logic               fifo_pop_s;
    logic               fifo_pop_valid_s;
    logic [ADDR_W-1:0]  fifo_head_addr_s;
    logic [DATA_W-1:0]  fifo_head_data_s;
    logic               bypass_s;

    logic               rf_wena_s;
    logic [ADDR_W-1:0]  rf_waddr_s;
    logic [DATA_W-1:0]  rf_wdata_s;

    logic [NUM_GPR-1:0] set_vec_s;
    logic [NUM_GPR-1:0] clr_vec_s;
    logic               err_done_s;
    logic               err_issue_s;
    logic               issue_stall_s;

    // Result handshake; a write to the zero register is accepted but dropped.
    always_comb begin
        wb_req_s.valid  = wb_valid && (wb_addr != ZERO_REG);
        wb_req_s.addr   = wb_addr;
        wb_req_s.data   = wb_data;
        lu_done_ready_s = !rst && fifo_push_ready_s;
        lu_accept_s     = lu_done_valid && lu_done_ready_s;
        lu_nonzero_s    = (lu_done_addr != ZERO_REG);
        fifo_push_s     = lu_accept_s && lu_nonzero_s && !bypass_s;
    end

    // Fixed-priority arbitration of the single regfile write port.
    always_comb begin
        rf_wena_s  = 1'b0;
        rf_waddr_s = '0;
        rf_wdata_s = '0;
        fifo_pop_s = 1'b0;
        bypass_s   = 1'b0;
        if (rst) begin
            rf_wena_s = 1'b0;
        end else if (wb_req_s.valid) begin
            rf_wena_s  = 1'b1;
            rf_waddr_s = wb_req_s.addr;
            rf_wdata_s = wb_req_s.data;
        end else if (fifo_pop_valid_s) begin
            rf_wena_s  = 1'b1;
            rf_waddr_s = fifo_head_addr_s;
            rf_wdata_s = fifo_head_data_s;
            fifo_pop_s = 1'b1;
        end else begin
`ifdef LU_WB_BYPASS_EN
            // Port idle and nothing queued ahead: write the result straight through.
            if (lu_accept_s && lu_nonzero_s) begin
                rf_wena_s  = 1'b1;
                rf_waddr_s = lu_done_addr;
                rf_wdata_s = lu_done_data;
                bypass_s   = 1'b1;
            end else begin
                rf_wena_s = 1'b0;
            end
`else
            rf_wena_s = 1'b0;
`endif
        end
    end

    wb_result_fifo #(
        .DEPTH  (QUEUE_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (fifo_push_s),
        .push_ready (fifo_push_ready_s),
        .push_addr  (lu_done_addr),
        .push_data  (lu_done_data),
        .pop        (fifo_pop_s),
        .pop_valid  (fifo_pop_valid_s),
        .head_addr  (fifo_head_addr_s),
        .head_data  (fifo_head_data_s)
    );

    // Scoreboard next state: a long-latency write clears, an issue sets, set wins.
    always_comb begin
        if (fifo_pop_s) begin
            clr_vec_s = gpr_onehot(fifo_head_addr_s);
        end else if (bypass_s) begin
            clr_vec_s = gpr_onehot(lu_done_addr);
        end else begin
            clr_vec_s = '0;
        end

        if (lu_issue_valid) begin
            set_vec_s = gpr_onehot(lu_issue_addr);
        end else begin
            set_vec_s = '0;
        end

        busy_d = (busy_q & ~clr_vec_s) | set_vec_s;
    end

    // Protocol errors: result for a register nobody waits on, or double issue.
    always_comb begin
        err_done_s  = lu_accept_s && lu_nonzero_s && !busy_q[lu_done_addr];
        err_issue_s = lu_issue_valid && (lu_issue_addr != ZERO_REG) && busy_q[lu_issue_addr];
        proto_err_d = proto_err_q || err_done_s || err_issue_s;
    end

    // ID hazard detection from the registered scoreboard; busy[0] is never set.
    always_comb begin
        if (rst) begin
            issue_stall_s = 1'b0;
        end else begin
            issue_stall_s = (id_rs_ena  && busy_q[id_rs_addr]) ||
                            (id_rt_ena  && busy_q[id_rt_addr]) ||
                            (id_rd_wena && busy_q[id_rd_addr]);
        end
    end

    // Scoreboard and error-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Output drive.
    always_comb begin
        lu_done_ready = lu_done_ready_s;
        issue_stall   = issue_stall_s;
        rf_wena       = rf_wena_s;
        rf_waddr      = rf_waddr_s;
        rf_wdata      = rf_wdata_s;
        busy_mask     = busy_q;
        proto_err     = proto_err_q;
    end

endmodule : regfile_wb_scheduler

// File: tb/tb_regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//   Directed scenarios followed by randomized traffic. A reference model
//   (busy array + queue of pending results) predicts each cycle's regfile
//   write, which is pushed into a scoreboard queue tagged with its cycle; a
//   separate monitor pops and compares whenever a write is due or rf_wena is
//   seen. Scoreboard-independent outputs are checked by the driver.
// ---------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        lu_issue_valid = 1'b0;
    logic [4:0]  lu_issue_addr = 5'd0;
    logic        lu_done_valid = 1'b0;
    logic [4:0]  lu_done_addr = 5'd0;
    logic [31:0] lu_done_data = 32'd0;
    logic        lu_done_ready;
    logic [4:0]  id_rs_addr = 5'd0;
    logic        id_rs_ena = 1'b0;
    logic [4:0]  id_rt_addr = 5'd0;
    logic        id_rt_ena = 1'b0;
    logic [4:0]  id_rd_addr = 5'd0;
    logic        id_rd_wena = 1'b0;
    logic        issue_stall;
    logic        rf_wena;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;
    logic        proto_err;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.ADDR_W(5), .DATA_W(32), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_issue_valid(lu_issue_valid), .lu_issue_addr(lu_issue_addr),
        .lu_done_valid(lu_done_valid), .lu_done_addr(lu_done_addr),
        .lu_done_data(lu_done_data), .lu_done_ready(lu_done_ready),
        .id_rs_addr(id_rs_addr), .id_rs_ena(id_rs_ena),
        .id_rt_addr(id_rt_addr), .id_rt_ena(id_rt_ena),
        .id_rd_addr(id_rd_addr), .id_rd_wena(id_rd_wena),
        .issue_stall(issue_stall),
        .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask), .proto_err(proto_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [4:0] addr; logic [31:0] data; } res_t;
    wr_t  exp_q[$];

    // reference model state
    bit   m_busy [32];
    res_t m_pend[$];
    bit   m_err;

    // stimulus for the next cycle
    bit          s_rst;
    bit          s_wb_v;   logic [4:0] s_wb_a;   logic [31:0] s_wb_d;
    bit          s_iss_v;  logic [4:0] s_iss_a;
    bit          s_done_v; logic [4:0] s_done_a; logic [31:0] s_done_d;
    bit          s_rs_e;   logic [4:0] s_rs_a;
    bit          s_rt_e;   logic [4:0] s_rt_a;
    bit          s_rd_w;   logic [4:0] s_rd_a;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle();
        s_rst = 1'b0;
        s_wb_v = 1'b0;   s_wb_a = 5'd0;   s_wb_d = 32'd0;
        s_iss_v = 1'b0;  s_iss_a = 5'd0;
        s_done_v = 1'b0; s_done_a = 5'd0; s_done_d = 32'd0;
        s_rs_e = 1'b0;   s_rs_a = 5'd0;
        s_rt_e = 1'b0;   s_rt_a = 5'd0;
        s_rd_w = 1'b0;   s_rd_a = 5'd0;
    endtask

    // One clock cycle: apply stimulus, predict, check at negedge, advance model.
    task automatic cycle();
        bit ready, acc, wr, from_lu, bypassed, stall;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] mask;
        @(posedge clk);
        #1;
        rst = s_rst;
        wb_valid = s_wb_v; wb_addr = s_wb_a; wb_data = s_wb_d;
        lu_issue_valid = s_iss_v; lu_issue_addr = s_iss_a;
        lu_done_valid = s_done_v; lu_done_addr = s_done_a; lu_done_data = s_done_d;
        id_rs_ena = s_rs_e; id_rs_addr = s_rs_a;
        id_rt_ena = s_rt_e; id_rt_addr = s_rt_a;
        id_rd_wena = s_rd_w; id_rd_addr = s_rd_a;
        cyc++;

        ready = !s_rst && (m_pend.size() < QD);
        acc   = s_done_v && ready;
        wr = 1'b0; from_lu = 1'b0; bypassed = 1'b0; wa = 5'd0; wd = 32'd0;
        if (!s_rst) begin
            if (s_wb_v && s_wb_a != 5'd0) begin
                wr = 1'b1; wa = s_wb_a; wd = s_wb_d;
            end else if (m_pend.size() > 0) begin
                wr = 1'b1; wa = m_pend[0].addr; wd = m_pend[0].data; from_lu = 1'b1;
                void'(m_pend.pop_front());
            end
`ifdef LU_WB_BYPASS_EN
            else if (acc && s_done_a != 5'd0) begin
                wr = 1'b1; wa = s_done_a; wd = s_done_d; from_lu = 1'b1; bypassed = 1'b1;
            end
`endif
        end
        if (wr) exp_q.push_back('{cyc, wa, wd});

        stall = !s_rst && ((s_rs_e && m_busy[s_rs_a]) || (s_rt_e && m_busy[s_rt_a]) ||
                           (s_rd_w && m_busy[s_rd_a]));
        for (int i = 0; i < 32; i++) mask[i] = m_busy[i];

        @(negedge clk);
        chk("lu_done_ready", {63'd0, lu_done_ready}, {63'd0, ready});
        chk("issue_stall", {63'd0, issue_stall}, {63'd0, stall});
        chk("busy_mask", {32'd0, busy_mask}, {32'd0, mask});
        chk("proto_err", {63'd0, proto_err}, {63'd0, m_err});
        if (!wr) chk("idle_port_zero", {27'd0, rf_waddr, rf_wdata}, 64'd0);

        if (s_rst) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
            m_pend.delete();
            m_err = 1'b0;
        end else begin
            if (acc && s_done_a != 5'd0 && !m_busy[s_done_a]) m_err = 1'b1;
            if (s_iss_v && s_iss_a != 5'd0 && m_busy[s_iss_a]) m_err = 1'b1;
            if (acc && s_done_a != 5'd0 && !bypassed) m_pend.push_back('{s_done_a, s_done_d});
            if (from_lu) m_busy[wa] = 1'b0;
            if (s_iss_v && s_iss_a != 5'd0) m_busy[s_iss_a] = 1'b1;
        end
    endtask

    // Scoreboard monitor: every rf write must match the predicted one for this cycle.
    always @(negedge clk) begin
        wr_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            total++;
            if (rf_wena !== 1'b1 || rf_waddr !== e.addr || rf_wdata !== e.data) begin
                bad++;
                $display("FAIL rf_write cyc=%0d actual wena=%b addr=%0d data=%h expected addr=%0d data=%h",
                         cyc, rf_wena, rf_waddr, rf_wdata, e.addr, e.data);
            end
        end else if (rf_wena !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL rf_spurious cyc=%0d actual wena=%b addr=%0d data=%h expected wena=0",
                     cyc, rf_wena, rf_waddr, rf_wdata);
        end
    end

    function automatic logic [4:0] pick_free();
        logic [4:0] a;
        a = 5'($urandom_range(0, 15));
        for (int t = 0; t < 4 && m_busy[a] && $urandom_range(0, 9) != 0; t++)
            a = 5'($urandom_range(1, 15));
        return a;
    endfunction

    function automatic logic [4:0] pick_busy();
        logic [4:0] lst[$];
        for (int i = 1; i < 32; i++) if (m_busy[i]) lst.push_back(5'(i));
        if (lst.size() > 0 && $urandom_range(0, 15) != 0)
            return lst[$urandom_range(0, lst.size() - 1)];
        return 5'($urandom_range(0, 15));
    endfunction

    initial begin
        idle();
        m_err = 1'b0;
        s_rst = 1'b1; cycle(); cycle();
        chk("reset_busy", {32'd0, busy_mask}, 64'd0);
        chk("reset_ready", {63'd0, lu_done_ready}, 64'd0);

        // basic path and hazards on $8
        idle(); s_iss_v = 1'b1; s_iss_a = 5'd8; cycle();
        idle(); s_rs_e = 1'b1; s_rs_a = 5'd8; cycle();
        chk("busy8_set", {32'd0, busy_mask}, 64'h100);
        chk("stall_raw8", {63'd0, issue_stall}, 64'd1);
        idle(); s_rs_e = 1'b1; s_rs_a = 5'd9; cycle();
        chk("nostall_rs9", {63'd0, issue_stall}, 64'd0);
        idle(); s_rd_w = 1'b1; s_rd_a = 5'd8; cycle();
        chk("stall_waw8", {63'd0, issue_stall}, 64'd1);
        idle(); s_done_v = 1'b1; s_done_a = 5'd8; s_done_d = 32'h1234; s_rs_e = 1'b1; s_rs_a = 5'd8; cycle();
`ifdef LU_WB_BYPASS_EN
        chk("bypass_write8", {26'd0, rf_wena, rf_waddr, rf_wdata}, {26'd0, 1'b1, 5'd8, 32'h1234});
`endif
        idle(); s_rs_e = 1'b1; s_rs_a = 5'd8; cycle();
`ifndef LU_WB_BYPASS_EN
        chk("lat1_write8", {26'd0, rf_wena, rf_waddr, rf_wdata}, {26'd0, 1'b1, 5'd8, 32'h1234});
        chk("stall_until_write", {63'd0, issue_stall}, 64'd1);
`endif
        idle(); s_rs_e = 1'b1; s_rs_a = 5'd8; cycle();
        chk("busy8_clr", {32'd0, busy_mask}, 64'd0);
        chk("stall_drop", {63'd0, issue_stall}, 64'd0);

        // contention: WB $3 every cycle while $5 and $6 results arrive
        idle(); s_iss_v = 1'b1; s_iss_a = 5'd5; cycle();
        idle(); s_iss_v = 1'b1; s_iss_a = 5'd6; cycle();
        idle(); s_wb_v = 1'b1; s_wb_a = 5'd3; s_wb_d = 32'hA; s_done_v = 1'b1; s_done_a = 5'd5; s_done_d = 32'h55; cycle();
        idle(); s_wb_v = 1'b1; s_wb_a = 5'd3; s_wb_d = 32'hA; s_done_v = 1'b1; s_done_a = 5'd6; s_done_d = 32'h66; cycle();
        idle(); s_wb_v = 1'b1; s_wb_a = 5'd3; s_wb_d = 32'hA; s_done_v = 1'b1; s_done_a = 5'd7; s_done_d = 32'h77; cycle();
        chk("full_not_ready", {63'd0, lu_done_ready}, 64'd0);
        chk("wb_has_port", {27'd0, rf_waddr, rf_wdata}, {27'd0, 5'd3, 32'hA});
        idle(); cycle();
        chk("drain_first5", {27'd0, rf_waddr, rf_wdata}, {27'd0, 5'd5, 32'h55});
        idle(); cycle();
        chk("drain_then6", {27'd0, rf_waddr, rf_wdata}, {27'd0, 5'd6, 32'h66});

        // zero register: WB to $0 frees the port; result to $0 is discarded
        idle(); s_iss_v = 1'b1; s_iss_a = 5'd10; cycle();
        idle(); s_wb_v = 1'b1; s_wb_a = 5'd3; s_wb_d = 32'hB; s_done_v = 1'b1; s_done_a = 5'd10; s_done_d = 32'hAA; cycle();
        idle(); s_wb_v = 1'b1; s_wb_a = 5'd0; s_wb_d = 32'hFF; cycle();
        chk("wb0_frees_port", {26'd0, rf_wena, rf_waddr, rf_wdata}, {26'd0, 1'b1, 5'd10, 32'hAA});
        idle(); s_done_v = 1'b1; s_done_a = 5'd0; s_done_d = 32'h5; cycle();
        idle(); cycle();
        chk("zero_busy", {32'd0, busy_mask}, 64'd0);
        chk("zero_no_err", {63'd0, proto_err}, 64'd0);

        // same-cycle set/clear on $7 (the re-issue also flags a protocol error)
        idle(); s_iss_v = 1'b1; s_iss_a = 5'd7; cycle();
        idle(); s_wb_v = 1'b1; s_wb_a = 5'd3; s_wb_d = 32'hC; s_done_v = 1'b1; s_done_a = 5'd7; s_done_d = 32'h70; cycle();
        idle(); s_iss_v = 1'b1; s_iss_a = 5'd7; cycle();
        idle(); cycle();
        chk("set_wins7", {63'd0, busy_mask[7]}, 64'd1);

        // errors and reset
        idle(); s_rst = 1'b1; cycle();
        idle(); s_done_v = 1'b1; s_done_a = 5'd4; s_done_d = 32'h44; cycle();
        idle(); cycle();
        chk("err_nonbusy4", {63'd0, proto_err}, 64'd1);
        idle(); s_iss_v = 1'b1; s_iss_a = 5'd11; cycle();
        idle(); s_iss_v = 1'b1; s_iss_a = 5'd12; cycle();
        idle(); s_wb_v = 1'b1; s_wb_a = 5'd3; s_done_v = 1'b1; s_done_a = 5'd11; s_done_d = 32'hB1; cycle();
        idle(); s_wb_v = 1'b1; s_wb_a = 5'd3; s_done_v = 1'b1; s_done_a = 5'd12; s_done_d = 32'hC1; cycle();
        idle(); s_rst = 1'b1; cycle();
        idle(); cycle();
        chk("rst_busy0", {32'd0, busy_mask}, 64'd0);
        chk("rst_err0", {63'd0, proto_err}, 64'd0);
        chk("rst_no_replay", {63'd0, rf_wena}, 64'd0);
        idle(); cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            s_rst  = ($urandom_range(0, 599) == 0);
            s_wb_v = ($urandom_range(0, 9) < 6);
            s_wb_a = 5'($urandom_range(0, 31));
            s_wb_d = $urandom();
            if ($urandom_range(0, 9) < 3) begin
                s_iss_v = 1'b1; s_iss_a = pick_free();
            end
            if ($urandom_range(0, 9) < 4) begin
                s_done_v = 1'b1; s_done_a = pick_busy(); s_done_d = $urandom();
            end
            s_rs_e = 1'($urandom_range(0, 1)); s_rs_a = 5'($urandom_range(0, 15));
            s_rt_e = 1'($urandom_range(0, 1)); s_rt_a = 5'($urandom_range(0, 15));
            s_rd_w = 1'($urandom_range(0, 1)); s_rd_a = 5'($urandom_range(0, 15));
            cycle();
        end
        idle(); cycle(); cycle(); cycle();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_wb_scheduler

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Schedules the single register-file write port between the pipeline WB stage and a long-latency unit (MUL/DIV results targeting GPRs). Keeps a 32-entry busy scoreboard of GPRs awaiting long-latency results and raises an ID-stage stall on RAW/WAW hits. Late results are buffered in a small FIFO until the port is free. Sits between WB, the mul/div unit and the register file write inputs.

Parameters:
ADDR_W, 5, GPR address width
DATA_W, 32, GPR data width
QUEUE_DEPTH, 2, long-latency result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
wb_valid  in  1  pipeline WB write request
wb_addr  in  ADDR_W  WB destination
wb_data  in  DATA_W  WB data
lu_issue_valid  in  1  long-latency op issued this cycle
lu_issue_addr  in  ADDR_W  its destination GPR
lu_done_valid  in  1  long-latency result offered
lu_done_addr  in  ADDR_W  result destination
lu_done_data  in  DATA_W  result data
lu_done_ready  out  1  result accepted when valid&&ready
id_rs_addr  in  ADDR_W  ID rs
id_rs_ena  in  1  rs is read
id_rt_addr  in  ADDR_W  ID rt
id_rt_ena  in  1  rt is read
id_rd_addr  in  ADDR_W  ID destination
id_rd_wena  in  1  ID instruction writes a GPR
issue_stall  out  1  hold ID stage
rf_wena  out  1  to regfile write enable
rf_waddr  out  ADDR_W  to regfile write address
rf_wdata  out  DATA_W  to regfile write data
busy_mask  out  32  scoreboard state
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=1 at edge): busy_mask=0, FIFO emptied, proto_err=0. During the rst cycle lu_done_ready=0, rf_wena=0, issue_stall=0. Reset mid-operation drops queued results and pending busy bits; there is no replay.
- Write-port arbitration (combinational, per cycle, fixed priority):
  1. wb_valid && wb_addr!=0: rf_* = WB. The FIFO holds.
  2. Otherwise, if the FIFO is non-empty: rf_* = FIFO head; the head is popped at the edge.
  3. Otherwise rf_wena=0; rf_waddr and rf_wdata are driven 0.
- A WB write to addr 0 counts as no request and frees the port.
- FIFO:
  - lu_done_ready = !full (the pop in the same cycle is not considered).
  - Push when valid&&ready; push and pop may occur in the same cycle.
  - Minimum result-to-regfile latency is 1 cycle.
  - lu_done with addr 0 is accepted and discarded (not queued, no rf write).
- Scoreboard:
  - lu_issue_valid && addr!=0 sets busy[addr] at the edge.
  - A FIFO pop writing addr X clears busy[X] at the edge.
  - If set and clear hit the same address in the same cycle, set wins.
  - busy[0] is always 0.
- issue_stall = (id_rs_ena&&busy[rs]) | (id_rt_ena&&busy[rt]) | (id_rd_wena&&busy[rd]). The addr-0 terms are always 0. Uses registered busy_mask only.
- proto_err sets when an accepted lu_done targets a non-busy, non-zero register, or when lu_issue targets an already-busy register. It is cleared only by rst.
- Starvation: continuous WB traffic may hold the FIFO. The FIFO drains on any WB bubble, which the pipeline guarantees because issue_stall inserts bubbles.

Optional Feature:
- Macro: LU_WB_BYPASS_EN.
- Defined: when there is no WB request and the FIFO is empty, an lu_done handshake writes the regfile in the same cycle (rf_* = lu_done_*), clears busy at that edge and skips the FIFO. Result latency is 0.
- Undefined: every result passes through the FIFO, with 1-cycle minimum latency.

Decomposition:
- Shared package: ADDR_W, DATA_W, NUM_GPR=32, ZERO_REG=0, and a wb_req struct/typedef {valid, addr, data}.
- One natural sub-module: wb_result_fifo (synchronous FIFO, depth QUEUE_DEPTH, valid/ready push, pop/empty/full).

Test Plan:
- Basic path: issue to $8, then lu_done $8=0x1234 with no WB → busy[8] set; rf write $8=0x1234 one cycle after the handshake (0 cycles with LU_WB_BYPASS_EN); busy[8] then clears.
- Stall hazards: busy[8]=1 → ID rs=$8 read stalls; ID rd=$8 write (WAW) stalls; rs=$9 does not stall. The stall drops the cycle after the $8 write.
- Contention: WB $3=0xA continuously while results for $5 and $6 arrive → FIFO fills and ready=0. On the first WB bubble $5 is written, then $6 the next cycle, in order.
- Zero register: wb_addr=0 with a queued result → the queued result is written that cycle. lu_done to $0 is discarded, busy_mask stays 0, proto_err stays 0.
- Same-cycle set/clear: pop writes $7 while a new issue targets $7 → busy[7] remains 1.
- Errors and reset: lu_done to a non-busy $4 → proto_err=1. rst mid-queue → next cycle busy_mask=0, FIFO empty, proto_err=0, with no rf writes.
